// File: rtl/left_shift.sv
// rtl/left_shift.sv - registered logarithmic barrel shifter with shifted-out-ones flag.
// DIR selects logical left (0) or logical right (1); one-cycle latency.
module left_shift #(
  parameter int WIDTH = 8,
  parameter bit DIR   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] shift_o,
  output logic             ovf_o,
  output logic             valid_o
);

  localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] shift_d, shift_q;
  logic             ovf_d, ovf_q;
  logic             valid_q;
  logic             hi_set;

  assign hi_set = |b_i[WIDTH-1:SW];

  // Each stage records the bits it pushes off the edge; their union is the full discarded set.
  always_comb begin
    shift_d = a_i;
    ovf_d   = 1'b0;
    for (int k = 0; k < SW; k++) begin
      if (b_i[k]) begin
        if (DIR == 1'b0) begin
          ovf_d   = ovf_d | (|(shift_d >> (WIDTH - (1 << k))));
          shift_d = shift_d << (1 << k);
        end else begin
          ovf_d   = ovf_d | (|(shift_d << (WIDTH - (1 << k))));
          shift_d = shift_d >> (1 << k);
        end
      end
    end
    if (hi_set) begin
      shift_d = '0;
      ovf_d   = |a_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= en_i;
      if (en_i) begin
        shift_q <= shift_d;
        ovf_q   <= ovf_d;
      end
    end
  end

  assign shift_o = shift_q;
  assign ovf_o   = ovf_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_left_shift.sv
// tb/tb_left_shift.sv - directed bench for left_shift, both directions side by side.
module tb_left_shift;

  logic       clk;
  logic       rst_n;
  logic       en_i;
  logic [7:0] a_i;
  logic [7:0] b_i;
  logic [7:0] shl_o, shr_o;
  logic       ovfl_o, ovfr_o;
  logic       vall_o, valr_o;

  int tests;
  int fails;

  left_shift #(.WIDTH(8), .DIR(1'b0)) u_shl (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .a_i(a_i), .b_i(b_i),
    .shift_o(shl_o), .ovf_o(ovfl_o), .valid_o(vall_o)
  );

  left_shift #(.WIDTH(8), .DIR(1'b1)) u_shr (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .a_i(a_i), .b_i(b_i),
    .shift_o(shr_o), .ovf_o(ovfr_o), .valid_o(valr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] el, input logic eol,
                           input logic [7:0] er, input logic eor, input logic ev);
    check({tag, " shl"},   int'(shl_o),  int'(el));
    check({tag, " ovfl"},  int'(ovfl_o), int'(eol));
    check({tag, " shr"},   int'(shr_o),  int'(er));
    check({tag, " ovfr"},  int'(ovfr_o), int'(eor));
    check({tag, " vall"},  int'(vall_o), int'(ev));
    check({tag, " valr"},  int'(valr_o), int'(ev));
  endtask

  task automatic apply(input string tag, input logic en, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] el, input logic eol,
                       input logic [7:0] er, input logic eor);
    @(negedge clk);
    en_i = en;
    a_i  = a;
    b_i  = b;
    @(posedge clk);
    #1;
    check_all(tag, el, eol, er, eor, en);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    en_i  = 1'b1;
    a_i   = 8'hFF;
    b_i   = 8'h01;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

    @(negedge clk);
    en_i  = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("post_reset_idle", 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

    apply("b_108",   1'b1, 8'hD3, 8'h6C, 8'h00, 1'b1, 8'h00, 1'b1);
    apply("d3_b3",   1'b1, 8'hD3, 8'h03, 8'h98, 1'b1, 8'h1A, 1'b1);
    apply("13_b3",   1'b1, 8'h13, 8'h03, 8'h98, 1'b0, 8'h02, 1'b1);
    apply("d0_b4",   1'b1, 8'hD0, 8'h04, 8'h00, 1'b1, 8'h0D, 1'b0);
    apply("a5_b0",   1'b1, 8'hA5, 8'h00, 8'hA5, 1'b0, 8'hA5, 1'b0);
    apply("01_b7",   1'b1, 8'h01, 8'h07, 8'h80, 1'b0, 8'h00, 1'b1);
    apply("ff_b8",   1'b1, 8'hFF, 8'h08, 8'h00, 1'b1, 8'h00, 1'b1);
    apply("00_b8",   1'b1, 8'h00, 8'h08, 8'h00, 1'b0, 8'h00, 1'b0);
    apply("80_b1",   1'b1, 8'h80, 8'h01, 8'h00, 1'b1, 8'h40, 1'b0);
    apply("hold",    1'b0, 8'h5A, 8'h02, 8'h00, 1'b1, 8'h40, 1'b0);

    apply("stream0", 1'b1, 8'h81, 8'h01, 8'h02, 1'b1, 8'h40, 1'b1);
    apply("stream1", 1'b1, 8'h0F, 8'h02, 8'h3C, 1'b0, 8'h03, 1'b1);
    apply("stream2", 1'b1, 8'h30, 8'h04, 8'h00, 1'b1, 8'h03, 1'b0);

    #2;
    rst_n = 1'b0;
    en_i  = 1'b0;
    #1;
    check_all("async_reset", 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("after_release_idle", 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    apply("after_release", 1'b1, 8'h0C, 8'h02, 8'h30, 1'b0, 8'h03, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
